// File: rtl/video_timing_generator.sv
// Raster timing source: walks x/y over a configurable video mode and registers the
// sync/enable/strobe decode of each position. Optional colour-bar pattern via VTG_COLOR_BAR_EN.
module video_timing_generator #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter bit          H_SYNC_ACTIVE = 1'b0,
    parameter bit          V_SYNC_ACTIVE = 1'b0,
    parameter int unsigned COUNT_WIDTH   = 12
) (
    input  logic                   pixel_clock,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic                   video_data_enable,
    output logic                   hsync,
    output logic                   vsync,
    output logic [COUNT_WIDTH-1:0] x,
    output logic [COUNT_WIDTH-1:0] y,
    output logic                   line_start,
`ifdef VTG_COLOR_BAR_EN
    output logic [23:0]            pattern_rgb,
`endif
    output logic                   frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COUNT_WIDTH-1:0] H_LAST     = COUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] V_LAST     = COUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] H_ACT_END  = COUNT_WIDTH'(H_ACTIVE);
    localparam logic [COUNT_WIDTH-1:0] V_ACT_END  = COUNT_WIDTH'(V_ACTIVE);
    localparam logic [COUNT_WIDTH-1:0] H_SYNC_BEG = COUNT_WIDTH'(H_ACTIVE + H_FRONT);
    localparam logic [COUNT_WIDTH-1:0] H_SYNC_END = COUNT_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COUNT_WIDTH-1:0] V_SYNC_BEG = COUNT_WIDTH'(V_ACTIVE + V_FRONT);
    localparam logic [COUNT_WIDTH-1:0] V_SYNC_END = COUNT_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                   de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic                   ls_q, ls_d, fs_q, fs_d;
    logic                   decode;

`ifdef VTG_COLOR_BAR_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    // Guard the divisor so very narrow modes still elaborate; bar region is then empty.
    localparam logic [COUNT_WIDTH-1:0] BAR_DIV = COUNT_WIDTH'((BAR_W == 0) ? 1 : BAR_W);
    localparam logic [COUNT_WIDTH-1:0] BAR_END = COUNT_WIDTH'(8 * BAR_W);

    logic [23:0]            rgb_q, rgb_d;
    logic [COUNT_WIDTH-1:0] bar_idx;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        de_d    = de_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        decode  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRun;
                    x_d     = '0;
                    y_d     = '0;
                    decode  = 1'b1;
                end
            end
            StRun: begin
                if (enable) begin
                    decode = 1'b1;
                    if (x_q == H_LAST) begin
                        x_d = '0;
                        y_d = (y_q == V_LAST) ? '0 : y_q + COUNT_WIDTH'(1);
                    end else begin
                        x_d = x_q + COUNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are the decode of the position being loaded, so they line up with x/y.
        if (decode) begin
            de_d = (x_d < H_ACT_END) && (y_d < V_ACT_END);
            hs_d = ((x_d >= H_SYNC_BEG) && (x_d < H_SYNC_END)) ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
            vs_d = ((y_d >= V_SYNC_BEG) && (y_d < V_SYNC_END)) ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
            ls_d = (x_d == '0);
            fs_d = (x_d == '0) && (y_d == '0);
        end
    end

`ifdef VTG_COLOR_BAR_EN
    always_comb begin
        rgb_d   = rgb_q;
        bar_idx = x_d / BAR_DIV;
        if (decode) begin
            rgb_d = 24'h000000;
            if (de_d && (x_d < BAR_END)) begin
                case (bar_idx)
                    COUNT_WIDTH'(0): rgb_d = 24'hFFFFFF;
                    COUNT_WIDTH'(1): rgb_d = 24'hFFFF00;
                    COUNT_WIDTH'(2): rgb_d = 24'h00FFFF;
                    COUNT_WIDTH'(3): rgb_d = 24'h00FF00;
                    COUNT_WIDTH'(4): rgb_d = 24'hFF00FF;
                    COUNT_WIDTH'(5): rgb_d = 24'hFF0000;
                    COUNT_WIDTH'(6): rgb_d = 24'h0000FF;
                    default:         rgb_d = 24'h000000;
                endcase
            end
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign pattern_rgb = rgb_q;
`endif

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~H_SYNC_ACTIVE;
            vs_q    <= ~V_SYNC_ACTIVE;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign x                 = x_q;
    assign y                 = y_q;
    assign video_data_enable = de_q;
    assign hsync             = hs_q;
    assign vsync             = vs_q;
    assign line_start        = ls_q;
    assign frame_start       = fs_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator using a small mode: H 20/2/3/3 (total 28),
// V 6/2/2/2 (total 12), so one frame is 336 cycles. hsync low x=22..24, vsync low y=8..9.
module tb_video_timing_generator;

    localparam int unsigned CW = 12;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          de, hs, vs, ls, fs;
    logic [CW-1:0] x, y;
`ifdef VTG_COLOR_BAR_EN
    logic [23:0]   rgb;
`endif

    int checks   = 0;
    int failures = 0;

    video_timing_generator #(
        .H_ACTIVE     (20),
        .H_FRONT      (2),
        .H_SYNC       (3),
        .H_BACK       (3),
        .V_ACTIVE     (6),
        .V_FRONT      (2),
        .V_SYNC       (2),
        .V_BACK       (2),
        .H_SYNC_ACTIVE(1'b0),
        .V_SYNC_ACTIVE(1'b0),
        .COUNT_WIDTH  (CW)
    ) dut (
        .pixel_clock      (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .video_data_enable(de),
        .hsync            (hs),
        .vsync            (vs),
        .x                (x),
        .y                (y),
        .line_start       (ls),
`ifdef VTG_COLOR_BAR_EN
        .pattern_rgb      (rgb),
`endif
        .frame_start      (fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            n;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          de, hs, vs, ls, fs;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [28:0] obs();
        return {x, y, de, hs, vs, ls, fs};
    endfunction

    function automatic logic [28:0] pack(input logic [CW-1:0] ex, input logic [CW-1:0] ey,
                                         input logic ede, input logic ehs, input logic evs,
                                         input logic els, input logic efs);
        return {ex, ey, ede, ehs, evs, els, efs};
    endfunction

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {x,y,de,hs,vs,ls,fs}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [28:0] RESET_OBS = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        int cnt;
        bit found;

        //          n    x   y  de hs vs ls fs
        vecs[0]  = '{0,   0,  0, 1, 1, 1, 1, 1};
        vecs[1]  = '{1,   1,  0, 1, 1, 1, 0, 0};
        vecs[2]  = '{19, 19,  0, 1, 1, 1, 0, 0};
        vecs[3]  = '{20, 20,  0, 0, 1, 1, 0, 0};
        vecs[4]  = '{21, 21,  0, 0, 1, 1, 0, 0};
        vecs[5]  = '{22, 22,  0, 0, 0, 1, 0, 0};
        vecs[6]  = '{24, 24,  0, 0, 0, 1, 0, 0};
        vecs[7]  = '{25, 25,  0, 0, 1, 1, 0, 0};
        vecs[8]  = '{27, 27,  0, 0, 1, 1, 0, 0};
        vecs[9]  = '{28,  0,  1, 1, 1, 1, 1, 0};
        vecs[10] = '{162, 22, 5, 0, 0, 1, 0, 0};
        vecs[11] = '{168,  0, 6, 0, 1, 1, 1, 0};
        vecs[12] = '{223, 27, 7, 0, 1, 1, 0, 0};
        vecs[13] = '{224,  0, 8, 0, 1, 0, 1, 0};
        vecs[14] = '{279, 27, 9, 0, 1, 0, 0, 0};
        vecs[15] = '{280,  0, 10, 0, 1, 1, 1, 0};
        vecs[16] = '{335, 27, 11, 0, 1, 1, 0, 0};
        vecs[17] = '{336,  0, 0, 1, 1, 1, 1, 1};
        vecs[18] = '{337,  1, 0, 1, 1, 1, 0, 0};

        reset_n = 1'b0;
        enable  = 1'b0;
        #22;
        check("reset_values", obs(), RESET_OBS);
`ifdef VTG_COLOR_BAR_EN
        checks++;
        if (rgb !== 24'h0) begin
            failures++;
            $display("FAIL rgb_reset: got %h expected 000000", rgb);
        end
`endif

        // Out of reset with enable low: stays idle.
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        check("idle_hold", obs(), RESET_OBS);

        // Free-running walk through one full frame and into the next.
        @(negedge clk);
        enable = 1'b1;
        n = -1;
        foreach (vecs[i]) begin
            while (n < vecs[i].n) begin
                step();
                n++;
            end
            check($sformatf("walk_n%0d", vecs[i].n), obs(),
                  pack(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].hs, vecs[i].vs,
                       vecs[i].ls, vecs[i].fs));
        end

        // Freeze on a line-start position (0,4): strobe must drop, levels hold.
        while (n < 336 + 112) begin
            step();
            n++;
        end
        check("pre_freeze", obs(), pack(0, 4, 1, 1, 1, 1, 0));
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("frozen_%0d", k), obs(), pack(0, 4, 1, 1, 1, 0, 0));
        end
        enable = 1'b1;
        step();
        check("resume", obs(), pack(1, 4, 1, 1, 1, 0, 0));

        // Next frame_start is (336 - 113) edges after (1,4).
        cnt   = 0;
        found = 1'b0;
        while (!found && cnt < 400) begin
            step();
            cnt++;
            if (fs) found = 1'b1;
        end
        checks++;
        if (!found || cnt != 223) begin
            failures++;
            $display("FAIL frame_after_freeze: got %0d edges (found=%0b) expected 223", cnt, found);
        end

        // Asynchronous reset between edges.
        for (int k = 0; k < 5; k++) step();
        check("pre_async_reset", obs(), pack(5, 0, 1, 1, 1, 0, 0));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", obs(), RESET_OBS);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("restart", obs(), pack(0, 0, 1, 1, 1, 1, 1));

`ifdef VTG_COLOR_BAR_EN
        // Bars are 2 pixels wide; x=16..19 lie past the last full bar.
        begin
            int          bx[8]   = '{1, 2, 4, 12, 14, 16, 19, 20};
            logic [23:0] brgb[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h0000FF,
                                     24'h000000, 24'h000000, 24'h000000, 24'h000000};
            int          cx = 0;
            foreach (bx[i]) begin
                while (cx < bx[i]) begin
                    step();
                    cx++;
                end
                checks++;
                if (rgb !== brgb[i] || x !== CW'(bx[i])) begin
                    failures++;
                    $display("FAIL rgb_x%0d: got rgb=%h x=%0d expected rgb=%h", bx[i], rgb, x,
                             brgb[i]);
                end
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
